// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU op codes,
// sequencer state encoding, instruction field positions, default widths and
// the per-instruction control bundle produced by the field decoder.
package cpu_pkg;

   localparam int DATA_W_DEF     = 18;
   localparam int REG_ADDR_W_DEF = 4;
   localparam int PC_W_DEF       = 10;

   // Instruction field positions (18-bit instruction word)
   localparam int OP_MSB  = 17;
   localparam int OP_LSB  = 14;
   localparam int F1_MSB  = 13;  // rd / ST data reg / BEQ rs1
   localparam int F1_LSB  = 10;
   localparam int F2_MSB  = 9;   // rs1 / ST base / BEQ rs2
   localparam int F2_LSB  = 6;
   localparam int F3_MSB  = 5;   // R-type rs2
   localparam int F3_LSB  = 2;
   localparam int IMM_MSB = 5;   // imm6 / off6
   localparam int IMM_W   = 6;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_ADDI = 4'd5,
      OP_LD   = 4'd6,
      OP_ST   = 4'd7,
      OP_BEQ  = 4'd8,
      OP_JMP  = 4'd9,
      OP_HLT  = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      READ   = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_e;

   typedef struct packed {
      logic       uses_rs1;
      logic       uses_rs2;
      logic       writes_rd;
      logic [2:0] alu_op;
      logic       src_imm;
      logic       is_mem;
      logic       is_branch;  // BEQ or JMP
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational opcode decoder.
//   op        : instruction opcode (Instr[17:14])
//   uses_rs1  : first register operand is read
//   uses_rs2  : second register operand is read
//   writes_rd : instruction writes back a destination register
//   alu_op    : ALU operation code
//   src_imm   : ALU B operand is the immediate
//   is_mem    : LD or ST
//   is_branch : BEQ or JMP (may redirect the PC)
//   illegal   : undefined opcode (10-14)
module instr_field_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] op,
   output logic       uses_rs1,
   output logic       uses_rs2,
   output logic       writes_rd,
   output logic [2:0] alu_op,
   output logic       src_imm,
   output logic       is_mem,
   output logic       is_branch,
   output logic       illegal
);

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      alu_op    = ALU_ADD;
      src_imm   = 1'b0;
      is_mem    = 1'b0;
      is_branch = 1'b0;
      illegal   = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            writes_rd = 1'b1;
            // R-type opcodes 0..4 coincide with the ALU op codes
            alu_op    = op[2:0];
         end
         OP_ADDI: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            src_imm   = 1'b1;
         end
         OP_LD: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            src_imm   = 1'b1;
            is_mem    = 1'b1;
         end
         OP_ST: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            src_imm   = 1'b1;
            is_mem    = 1'b1;
         end
         OP_BEQ: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            alu_op    = ALU_SUB;
            is_branch = 1'b1;
         end
         OP_JMP: begin
            is_branch = 1'b1;
         end
         OP_HLT: begin
         end
         default: begin
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer in front of the 16x18 register file.
// Accepts one instruction at a time over InstrValid/InstrReady, steps it
// through FETCH -> DECODE -> READ -> EXEC -> [MEM] -> [WB] -> FETCH and owns
// the PC. Ports:
//   Clk, Reset                : clock, async active-high reset
//   InstrValid/Instr/InstrReady : instruction handshake
//   PC                        : current program counter
//   ReadEnable*/ReadRegister* : register file read port control
//   ReadData1/2               : register file read data (branch compare)
//   WriteRegister/RegWrite    : register file write control
//   ALUOp/ALUSrcImm/Imm       : ALU control during EXEC
//   MemRead/MemWrite/MemDone  : data memory strobes and completion
//   IllegalOp                 : one-cycle pulse on undefined opcode
//   Halted                    : HLT executed, held until reset
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int PC_W       = PC_W_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  InstrValid,
   input  logic [DATA_W-1:0]     Instr,
   output logic                  InstrReady,
   output logic [PC_W-1:0]       PC,
   output logic                  ReadEnable1,
   output logic                  ReadEnable2,
   output logic [REG_ADDR_W-1:0] ReadRegister1,
   output logic [REG_ADDR_W-1:0] ReadRegister2,
   input  logic [DATA_W-1:0]     ReadData1,
   input  logic [DATA_W-1:0]     ReadData2,
   output logic [REG_ADDR_W-1:0] WriteRegister,
   output logic                  RegWrite,
   output logic [2:0]            ALUOp,
   output logic                  ALUSrcImm,
   output logic [DATA_W-1:0]     Imm,
   output logic                  MemRead,
   output logic                  MemWrite,
   input  logic                  MemDone,
   output logic                  IllegalOp,
   output logic                  Halted
);

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   ctrl_t               ctrl_q, ctrl_d;
   ctrl_t               dec;

   logic [3:0]            op;
   logic [REG_ADDR_W-1:0] f1, f2, f3;
   logic [REG_ADDR_W-1:0] rr1, rr2;
   logic [DATA_W-1:0]     imm_sext;
   logic [PC_W-1:0]       off_pc, pc_inc;

   assign op       = ir_q[OP_MSB:OP_LSB];
   assign f1       = ir_q[F1_MSB:F1_LSB];
   assign f2       = ir_q[F2_MSB:F2_LSB];
   assign f3       = ir_q[F3_MSB:F3_LSB];
   assign imm_sext = {{(DATA_W-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
   assign off_pc   = {{(PC_W-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:0]};
   assign pc_inc   = pc_q + 1'b1;

   // Operand register selection differs per format: BEQ keeps its sources in
   // the first two fields, ST keeps its data register where rd normally sits.
   assign rr1 = (op == OP_BEQ) ? f1 : f2;
   assign rr2 = (op == OP_ST)  ? f1 :
                (op == OP_BEQ) ? f2 : f3;

   instr_field_decoder u_dec (
      .op        (op),
      .uses_rs1  (dec.uses_rs1),
      .uses_rs2  (dec.uses_rs2),
      .writes_rd (dec.writes_rd),
      .alu_op    (dec.alu_op),
      .src_imm   (dec.src_imm),
      .is_mem    (dec.is_mem),
      .is_branch (dec.is_branch),
      .illegal   (dec.illegal)
   );

   // Next-state, datapath latches and PC update
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      pc_d    = pc_q;
      case (state_q)
         FETCH: begin
            if (InstrValid) begin
               ir_d    = Instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            ctrl_d  = dec;
            state_d = READ;
         end
         READ: begin
            a_d     = ReadData1;
            b_d     = ReadData2;
            state_d = EXEC;
         end
         EXEC: begin
            if (op == OP_HLT)          state_d = HALT;
            else if (ctrl_q.is_mem)    state_d = MEM;
            else if (ctrl_q.writes_rd) state_d = WB;
            else                       state_d = FETCH;
         end
         MEM: begin
            if (MemDone) state_d = (op == OP_LD) ? WB : FETCH;
         end
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase

      // PC advances only when an instruction retires back into FETCH
      if (state_q != FETCH && state_d == FETCH) begin
         pc_d = pc_inc;
         if (ctrl_q.is_branch) begin
            if (op == OP_JMP)     pc_d = ir_q[PC_W-1:0];
            else if (a_q == b_q)  pc_d = pc_inc + off_pc;
         end
      end
   end

   // Outputs decode purely from registered state so reset clears strobes
   // immediately
   always_comb begin
      InstrReady    = (state_q == FETCH);
      PC            = pc_q;
      ReadEnable1   = 1'b0;
      ReadEnable2   = 1'b0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;
      WriteRegister = '0;
      RegWrite      = 1'b0;
      ALUOp         = '0;
      ALUSrcImm     = 1'b0;
      Imm           = '0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IllegalOp     = 1'b0;
      Halted        = (state_q == HALT);
      if (state_q == DECODE || state_q == READ || state_q == EXEC) begin
         ReadRegister1 = rr1;
         ReadRegister2 = rr2;
      end
      if (state_q == READ || state_q == EXEC) begin
         ReadEnable1 = ctrl_q.uses_rs1;
         ReadEnable2 = ctrl_q.uses_rs2;
      end
      if (state_q == EXEC) begin
         ALUOp     = ctrl_q.alu_op;
         ALUSrcImm = ctrl_q.src_imm;
         Imm       = imm_sext;
         IllegalOp = ctrl_q.illegal;
      end
      if (state_q == MEM) begin
         MemRead  = (op == OP_LD);
         MemWrite = (op == OP_ST);
      end
      if (state_q == WB) begin
         RegWrite      = 1'b1;
         WriteRegister = f1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
      end
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control sequencer that sits directly upstream of the 16x18-bit register file.
- Accepts 18-bit instructions over a valid/ready handshake and decodes them.
- Drives the register file's read-enable, read-address, write-address and write-strobe ports.
- Consumes ReadData1/ReadData2 to resolve branches, owns the PC, and sequences ALU and memory control through a fixed FSM.

Parameters:
DATA_W, 18, datapath / instruction width
REG_ADDR_W, 4, register address width (16 registers)
PC_W, 10, program counter width

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
InstrValid  in  1  instruction word available
Instr  in  DATA_W  instruction word
InstrReady  out  1  sequencer can accept an instruction
PC  out  PC_W  current program counter
ReadEnable1, ReadEnable2  out  1  register file read enables
ReadRegister1, ReadRegister2  out  REG_ADDR_W  register file read addresses
ReadData1, ReadData2  in  DATA_W  register file read data
WriteRegister  out  REG_ADDR_W  destination register
RegWrite  out  1  register file write strobe
ALUOp  out  3  ADD=0 SUB=1 AND=2 OR=3 XOR=4
ALUSrcImm  out  1  ALU B operand is Imm
Imm  out  DATA_W  sign-extended immediate
MemRead, MemWrite  out  1  data memory strobes
MemDone  in  1  memory access complete
IllegalOp  out  1  one-cycle pulse on an undefined opcode
Halted  out  1  HLT executed

Behaviour:
- Instruction formats:
  - op = Instr[17:14].
  - R-type: rd[13:10], rs1[9:6], rs2[5:2].
  - I-type (ADDI/LD): rd[13:10], rs1[9:6], imm6[5:0].
  - ST: rs2(data)[13:10], rs1(base)[9:6], imm6[5:0].
  - BEQ: rs1[13:10], rs2[9:6], off6[5:0].
  - JMP: target = Instr[PC_W-1:0].
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDI, 6 LD, 7 ST, 8 BEQ, 9 JMP, 15 HLT; 10-14 illegal.
- Reset (asynchronous): state=FETCH; PC=0; IR=0. All outputs 0, except InstrReady=1 once in FETCH. RegWrite/MemWrite drop immediately, including mid-instruction.
- FETCH:
  - InstrReady=1.
  - On InstrValid&InstrReady at a rising edge, latch IR and go to DECODE.
  - No acceptance without InstrValid.
- DECODE (1 cycle):
  - Register control bundle from IR.
  - Drive ReadRegister1/2.
  - Go to READ.
- READ (1 cycle):
  - ReadEnableN=1 only for operands the opcode uses; held through EXEC.
  - Latch ReadData1/2 into A/B at cycle end.
- EXEC (1 cycle):
  - Drive ALUOp, ALUSrcImm and Imm = sext(imm6/off6).
  - ADDI/LD/ST use ADD with ALUSrcImm=1; BEQ uses SUB.
  - Next state: R-type/ADDI -> WB; LD/ST -> MEM; BEQ/JMP/illegal -> FETCH; HLT -> HALT.
  - Illegal opcode: IllegalOp=1 this cycle only; treated as NOP.
- MEM:
  - MemRead (LD) or MemWrite (ST) held until MemDone is sampled high.
  - Then LD -> WB, ST -> FETCH.
  - MemDone outside MEM is ignored.
- WB (1 cycle):
  - RegWrite=1 exactly one cycle, WriteRegister=rd.
  - Then go to FETCH.
  - R0 is writable (no hardwired zero).
- PC update on transition into FETCH:
  - Default PC+1.
  - BEQ taken (A==B): PC+1+sext(off6).
  - JMP: target.
  - All arithmetic modulo 2^PC_W; wrap 1023->0 is legal.
- HALT:
  - Halted=1, InstrReady=0.
  - Absorbing until Reset.
- Latency from acceptance edge to next InstrReady:
  - R/ADDI: 4 cycles.
  - BEQ/JMP/illegal: 3 cycles.
  - LD: 4 + MEM cycles.
  - ST: 3 + MEM cycles.
- Exactly one instruction in flight; no overlap, so no hazards.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants.
  - ALUOp codes.
  - State enum (FETCH, DECODE, READ, EXEC, MEM, WB, HALT).
  - Field bit positions.
  - DATA_W / REG_ADDR_W defaults.
- One combinational sub-module, instr_field_decoder: op -> {uses_rs1, uses_rs2, writes_rd, alu_op, src_imm, is_mem, is_branch, illegal}.

Test Plan:
- Reset asserted mid-WB of ADD -> RegWrite falls asynchronously; PC=0; state FETCH; InstrReady=1 next cycle.
- ADDI R5,R0,#-3 with ReadData1=10 -> ReadRegister1=0, ALUSrcImm=1, Imm=0x3FFFD. RegWrite pulses 1 cycle with WriteRegister=5, 4 cycles after acceptance; PC 0->1.
- LD R2,[R1+4] with MemDone delayed 3 cycles -> MemRead high exactly 3 cycles; then RegWrite with WriteRegister=2. ST never raises RegWrite.
- BEQ R3,R4,off=-2 at PC=7 with equal data -> PC=6; with unequal data -> PC=8; RegWrite never asserted.
- JMP 1023 then ADD -> PC=1023, then wraps to 0. Opcode 12 -> IllegalOp 1-cycle pulse, PC+1, no strobes.
- HLT -> Halted=1, InstrReady=0; InstrValid ignored for 20 cycles; Reset restores FETCH with PC=0.
